// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B) decoder producing a one-cycle step strobe and
// direction for a wrap-around position counter, and counting illegal phase jumps.
// Optional glitch filter: define QDEC_FILTER_EN to add a per-phase stability
// filter of FILTER_LEN cycles (legal range 2..15) behind the synchronizers.
module quad_decoder #(
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             qa,
   input  logic             qb,
   input  logic             err_clr,
   output logic             en,
   output logic             dir,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             ready
);

`ifdef QDEC_FILTER_EN
   localparam int unsigned WARM_LEN = 2 + FILTER_LEN;
`else
   localparam int unsigned WARM_LEN = 2;
`endif
   localparam int unsigned WARM_W = $clog2(FILTER_LEN + 3);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      ST_WARM  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       cur;
   logic [1:0]       prev_q;
   logic [1:0]       prev_n;
   logic [1:0]       pos_cur;
   logic [1:0]       pos_prev;
   logic [1:0]       step;
   logic [WARM_W-1:0] warm_q;
   logic [WARM_W-1:0] warm_n;
   state_t           state_q;
   state_t           state_n;
   logic             en_n;
   logic             dir_n;
   logic             err_n;
   logic [ERR_W-1:0] err_cnt_n;
   logic             ready_n;

   // Two-flop synchronizer for both phases; bit 1 = A, bit 0 = B.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= {qa, qb};
         sync2 <= sync1;
      end
   end

`ifdef QDEC_FILTER_EN
   localparam int unsigned FCNT_W = 4;

   logic [1:0]        filt;
   logic [FCNT_W-1:0] fcnt [0:1];

   // Per-phase stability filter: accept a new level after FILTER_LEN stable cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt    <= 2'b00;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FCNT_W'(1);
            end
         end
      end
   end

   assign cur = filt;
`else
   assign cur = sync2;
`endif

   // Map the Gray phase pair to a 0..3 position so a step is a signed difference.
   always_comb begin
      pos_cur  = {cur[0], cur[1] ^ cur[0]};
      pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
      step     = pos_cur - pos_prev;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_WARM;
         warm_q  <= '0;
         prev_q  <= 2'b00;
         en      <= 1'b0;
         dir     <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         state_q <= state_n;
         warm_q  <= warm_n;
         prev_q  <= prev_n;
         en      <= en_n;
         dir     <= dir_n;
         err     <= err_n;
         err_cnt <= err_cnt_n;
         ready   <= ready_n;
      end
   end

   // Next-state and decode logic.
   always_comb begin
      state_n   = state_q;
      warm_n    = warm_q;
      prev_n    = prev_q;
      en_n      = 1'b0;
      dir_n     = dir;
      err_n     = err;
      err_cnt_n = err_cnt;

      if (err_clr) begin
         err_n     = 1'b0;
         err_cnt_n = '0;
      end

      case (state_q)
         ST_WARM: begin
            if (warm_q == WARM_W'(WARM_LEN - 1)) begin
               state_n = ST_LOAD;
               warm_n  = '0;
            end else begin
               warm_n = warm_q + WARM_W'(1);
            end
         end
         ST_LOAD: begin
            prev_n  = cur;
            state_n = ST_TRACK;
         end
         ST_TRACK: begin
            case (step)
               2'd0: ;
               2'd1: begin
                  en_n   = 1'b1;
                  dir_n  = 1'b0;
                  prev_n = cur;
               end
               2'd3: begin
                  en_n   = 1'b1;
                  dir_n  = 1'b1;
                  prev_n = cur;
               end
               2'd2: begin
                  // Both phases moved: flag it and resynchronize to the new state.
                  prev_n = cur;
                  err_n  = 1'b1;
                  if (err_clr) begin
                     err_cnt_n = ERR_W'(1);
                  end else if (err_cnt != ERR_MAX) begin
                     err_cnt_n = err_cnt + ERR_W'(1);
                  end
               end
            endcase
         end
         default: state_n = ST_WARM;
      endcase

      ready_n = (state_n == ST_TRACK);
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: randomized encoder stimulus against a position-based
// reference model; expected step strobes are queued and checked by a monitor.
// Define QDEC_FILTER_EN for both bench and RTL to exercise the filter build.
module tb_quad_decoder;
   localparam int unsigned ERR_W   = 8;
   localparam int unsigned FLEN    = 4;
   localparam int          ERR_MAX = (1 << ERR_W) - 1;
`ifdef QDEC_FILTER_EN
   localparam int LAT     = 3 + FLEN;
   localparam int MIN_GAP = FLEN + 1;
`else
   localparam int LAT     = 3;
   localparam int MIN_GAP = 1;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             qa = 1'b0;
   logic             qb = 1'b0;
   logic             err_clr = 1'b0;
   logic             en;
   logic             dir;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             ready;

   quad_decoder #(.FILTER_LEN(FLEN), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset), .qa(qa), .qb(qb), .err_clr(err_clr),
      .en(en), .dir(dir), .err(err), .err_cnt(err_cnt), .ready(ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int   at;
      logic d;
   } exp_t;
   exp_t q[$];

   // Reference model: encoder position along 00 -> 10 -> 11 -> 01 (forward).
   logic [1:0] lvl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int   m_pos;
   logic m_err;
   int   m_cnt;
   logic exp_dir = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the queue; dir holds otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         exp_dir = 1'b0;
      end else if (en === 1'b1) begin
         if (q.size() == 0) begin
            check("en_unexpected", 32'(en), 32'd0);
         end else begin
            e = q.pop_front();
            check("en_cycle", 32'(cyc), 32'(e.at));
            check("en_dir", 32'(dir), 32'(e.d));
            exp_dir = e.d;
         end
      end else begin
         check("dir_hold", 32'(dir), 32'(exp_dir));
      end
   end

   // Move the encoder to position np (called at a negedge), then wait gap cycles.
   // clr_hit pulses err_clr on the edge that decodes this move.
   task automatic step_to(input int np, input int gap, input bit clr_hit);
      int   d;
      exp_t e;
      d = (np - m_pos + 4) % 4;
      if (d == 1 || d == 3) begin
         e.at = cyc + LAT;
         e.d  = (d == 3);
         q.push_back(e);
      end else if (d == 2) begin
         m_err = 1'b1;
         if (clr_hit) m_cnt = 1;
         else if (m_cnt < ERR_MAX) m_cnt++;
      end
      {qa, qb} = lvl[np];
      m_pos = np;
      if (clr_hit) begin
         repeat (LAT - 1) @(negedge clk);
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         repeat (gap - LAT) @(negedge clk);
      end else begin
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic settle();
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic check_err(input string tag);
      check({tag, "_err"}, 32'(err), 32'(m_err));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_cnt));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_en"}, 32'(en), 32'd0);
      check({tag, "_dir"}, 32'(dir), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_ready"}, 32'(ready), 32'd0);
   endtask

   // Deassert reset at a negedge; ready must stay low until the LAT-th edge.
   task automatic release_reset(input string tag);
      reset = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         check({tag, "_ready"}, 32'(ready), 32'(k == LAT));
      end
   endtask

   initial begin
      int r;
      int np;
      int saved;

      {qa, qb} = 2'b11;
      m_pos = 2;
      m_err = 1'b0;
      m_cnt = 0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      release_reset("rel");
      check_err("rel");

      for (int i = 0; i < 8; i++) step_to((m_pos + 1) % 4, 6, 1'b0);
      settle();
      for (int i = 0; i < 8; i++) step_to((m_pos + 3) % 4, 6, 1'b0);
      settle();

      while (m_pos != 0) step_to((m_pos + 1) % 4, MIN_GAP + 1, 1'b0);
      settle();
      step_to(2, 6, 1'b0);
      settle();
      check_err("illegal");
      step_to(3, 6, 1'b0);
      settle();

      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
      @(negedge clk);
      check_err("clr");

      for (int i = 0; i < 6; i++) step_to((m_pos + 1) % 4, MIN_GAP, 1'b0);
      settle();

      for (int i = 0; i < 150; i++) begin
         r  = $urandom_range(0, 9);
         np = (r == 0) ? (m_pos + 2) % 4 : (r <= 5) ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
         step_to(np, $urandom_range(MIN_GAP, MIN_GAP + 4), 1'b0);
      end
      settle();
      check_err("rand");

      for (int i = 0; i < 300; i++) step_to((m_pos + 2) % 4, MIN_GAP + 1, 1'b0);
      settle();
      check_err("sat");
      check("sat_max", 32'(err_cnt), 32'(ERR_MAX));

      step_to((m_pos + 2) % 4, LAT + 2, 1'b1);
      settle();
      check_err("clr_hit");

`ifdef QDEC_FILTER_EN
      saved = m_cnt;
      qa = ~qa;
      repeat (3) @(negedge clk);
      qa = ~qa;
      repeat (LAT + 3) @(negedge clk);
      check("glitch_err_cnt", 32'(err_cnt), 32'(saved));
      step_to((m_pos + 1) % 4, 6, 1'b0);
      settle();
`endif

      np = (m_pos + 1) % 4;
      {qa, qb} = lvl[np];
      m_pos = np;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("midrst");
      release_reset("midrel");
      step_to((m_pos + 3) % 4, 6, 1'b0);
      settle();
      check_err("final");

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
